llc_req_arbiter: RTL and testbench

Sequencer in front of the LLC model. It shares the single LLC command/address port between two requesters: L1 requests (trace cmds 0,1,2,8,9) and bus snoops (cmds 3,4,5,6).
- L1 requests are buffered in a small FIFO.
- Snoops are held in a one-entry slot and have priority, bounded by an anti-starvation limit.
- Each transaction is issued with a valid/ready handshake, and the block waits for LLC completion before issuing the next.

---
 rtl/llc_req_arbiter_pkg.sv | 27 ++
 rtl/llc_req_fifo.sv | 60 ++++++
 rtl/llc_req_arbiter.sv | 179 +++++++++++++++++
 tb/tb_llc_req_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_req_arbiter_pkg.sv
// Shared widths, trace command codes and FSM state type for the LLC request arbiter.
package llc_req_arbiter_pkg;

  localparam int unsigned CMDSIZE   = 4;
  localparam int unsigned ADDR_BITS = 32;

  localparam logic [CMDSIZE-1:0] RD_L1D   = 4'd0;
  localparam logic [CMDSIZE-1:0] WR_L1D   = 4'd1;
  localparam logic [CMDSIZE-1:0] RD_L1I   = 4'd2;
  localparam logic [CMDSIZE-1:0] SNP_INV  = 4'd3;
  localparam logic [CMDSIZE-1:0] SNP_RD   = 4'd4;
  localparam logic [CMDSIZE-1:0] SNP_WR   = 4'd5;
  localparam logic [CMDSIZE-1:0] SNP_RWIM = 4'd6;
  localparam logic [CMDSIZE-1:0] CLR      = 4'd8;
  localparam logic [CMDSIZE-1:0] PRT      = 4'd9;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} arb_state_t;

  function automatic logic is_l1_cmd(input logic [CMDSIZE-1:0] cmd);
    return cmd inside {RD_L1D, WR_L1D, RD_L1I, CLR, PRT};
  endfunction

  function automatic logic is_snp_cmd(input logic [CMDSIZE-1:0] cmd);
    return cmd inside {SNP_INV, SNP_RD, SNP_WR, SNP_RWIM};
  endfunction

endpackage

// File: rtl/llc_req_fifo.sv
// Synchronous FIFO holding buffered L1 requests; Depth must be a power of two (>= 2).
module llc_req_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 36,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count,
  output logic [CntW-1:0]  next_count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    next_count = count_q;
    if (push_ok && !pop_ok) begin
      next_count = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      next_count = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers are exactly log2(Depth) wide, so increments wrap modulo Depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= next_count;
    end
  end

endmodule

// File: rtl/llc_req_arbiter.sv
// Shares the LLC command port between buffered L1 requests and a priority snoop slot.
// Optional LLC_ARB_STATS_EN adds saturating grant/timeout counters.
module llc_req_arbiter
  import llc_req_arbiter_pkg::*;
#(
  parameter int unsigned L1_FIFO_DEPTH   = 4,
  parameter int unsigned MAX_SNOOP_BURST = 3,
  parameter int unsigned DONE_TIMEOUT    = 64,
  localparam int unsigned CntW = $clog2(L1_FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 l1_valid,
  output logic                 l1_ready,
  input  logic [CMDSIZE-1:0]   l1_cmd,
  input  logic [ADDR_BITS-1:0] l1_addr,
  input  logic                 snp_valid,
  output logic                 snp_ready,
  input  logic [CMDSIZE-1:0]   snp_cmd,
  input  logic [ADDR_BITS-1:0] snp_addr,
  output logic                 llc_valid,
  input  logic                 llc_ready,
  output logic [CMDSIZE-1:0]   llc_cmd,
  output logic [ADDR_BITS-1:0] llc_addr,
  input  logic                 llc_done,
  output logic                 busy,
  output logic                 illegal_cmd,
  output logic                 timeout,
`ifdef LLC_ARB_STATS_EN
  output logic [31:0]          snp_grants,
  output logic [31:0]          l1_grants,
  output logic [31:0]          timeouts,
`endif
  output logic [CntW-1:0]      l1_fifo_count
);

  localparam int unsigned BurstW = $clog2(MAX_SNOOP_BURST + 1);
  localparam int unsigned WaitW  = $clog2(DONE_TIMEOUT + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_SNOOP_BURST);
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(DONE_TIMEOUT - 1);

  arb_state_t                 state_q;
  logic                       l1_ready_q, snp_ready_q, illegal_q, timeout_q;
  logic                       slot_valid_q, slot_valid_d;
  logic [CMDSIZE-1:0]         slot_cmd_q;
  logic [ADDR_BITS-1:0]       slot_addr_q;
  logic [BurstW-1:0]          burst_q;
  logic [WaitW-1:0]           wait_cnt_q;
  logic                       llc_valid_q;
  logic [CMDSIZE-1:0]         llc_cmd_q;
  logic [ADDR_BITS-1:0]       llc_addr_q;

  logic                       l1_fire, snp_fire, l1_push, snp_store;
  logic                       grant_snp, grant_l1, wait_expired;
  logic                       fifo_full, fifo_empty;
  logic [CMDSIZE+ADDR_BITS-1:0] fifo_rdata;
  logic [CntW-1:0]            fifo_next_count;

  assign l1_fire   = l1_valid & l1_ready_q;
  assign snp_fire  = snp_valid & snp_ready_q;
  assign l1_push   = l1_fire & is_l1_cmd(l1_cmd) & ~fifo_full;
  assign snp_store = snp_fire & is_snp_cmd(snp_cmd);

  // Snoops win unless they have used up their burst while L1 work is waiting.
  assign grant_snp = (state_q == IDLE) && slot_valid_q && ((burst_q < BurstMax) || fifo_empty);
  assign grant_l1  = (state_q == IDLE) && !grant_snp && !fifo_empty;
  assign wait_expired = (state_q == WAIT_DONE) && !llc_done && (wait_cnt_q == WaitLast);
  assign slot_valid_d = snp_store | (slot_valid_q & ~grant_snp);

  llc_req_fifo #(
    .Depth (L1_FIFO_DEPTH),
    .Width (CMDSIZE + ADDR_BITS)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (l1_push),
    .wdata      ({l1_cmd, l1_addr}),
    .pop        (grant_l1),
    .rdata      (fifo_rdata),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (l1_fifo_count),
    .next_count (fifo_next_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      l1_ready_q   <= 1'b0;
      snp_ready_q  <= 1'b0;
      illegal_q    <= 1'b0;
      timeout_q    <= 1'b0;
      slot_valid_q <= 1'b0;
      slot_cmd_q   <= '0;
      slot_addr_q  <= '0;
      burst_q      <= '0;
      wait_cnt_q   <= '0;
      llc_valid_q  <= 1'b0;
      llc_cmd_q    <= '0;
      llc_addr_q   <= '0;
    end else begin
      l1_ready_q   <= (fifo_next_count < CntW'(L1_FIFO_DEPTH));
      snp_ready_q  <= ~slot_valid_d;
      illegal_q    <= (l1_fire && !is_l1_cmd(l1_cmd)) || (snp_fire && !is_snp_cmd(snp_cmd));
      timeout_q    <= 1'b0;
      slot_valid_q <= slot_valid_d;
      if (snp_store) begin
        slot_cmd_q  <= snp_cmd;
        slot_addr_q <= snp_addr;
      end
      case (state_q)
        IDLE: begin
          if (grant_snp) begin
            llc_cmd_q   <= slot_cmd_q;
            llc_addr_q  <= slot_addr_q;
            llc_valid_q <= 1'b1;
            state_q     <= ISSUE;
            if (fifo_empty)            burst_q <= '0;
            else if (burst_q != BurstMax) burst_q <= burst_q + BurstW'(1);
          end else if (grant_l1) begin
            llc_cmd_q   <= fifo_rdata[ADDR_BITS +: CMDSIZE];
            llc_addr_q  <= fifo_rdata[ADDR_BITS-1:0];
            llc_valid_q <= 1'b1;
            state_q     <= ISSUE;
            burst_q     <= '0;
          end
        end
        ISSUE: begin
          if (llc_ready) begin
            llc_valid_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= llc_done ? IDLE : WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (llc_done) begin
            state_q <= IDLE;
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign l1_ready    = l1_ready_q;
  assign snp_ready   = snp_ready_q;
  assign illegal_cmd = illegal_q;
  assign timeout     = timeout_q;
  assign llc_valid   = llc_valid_q;
  assign llc_cmd     = llc_cmd_q;
  assign llc_addr    = llc_addr_q;
  assign busy        = (state_q != IDLE);

`ifdef LLC_ARB_STATS_EN
  logic [31:0] snp_grants_q, l1_grants_q, timeouts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snp_grants_q <= '0;
      l1_grants_q  <= '0;
      timeouts_q   <= '0;
    end else begin
      if (grant_snp && snp_grants_q != '1)  snp_grants_q <= snp_grants_q + 32'd1;
      if (grant_l1 && l1_grants_q != '1)    l1_grants_q  <= l1_grants_q + 32'd1;
      if (wait_expired && timeouts_q != '1) timeouts_q   <= timeouts_q + 32'd1;
    end
  end

  assign snp_grants = snp_grants_q;
  assign l1_grants  = l1_grants_q;
  assign timeouts   = timeouts_q;
`endif

endmodule

// File: tb/tb_llc_req_arbiter.sv
// Scoreboard bench for llc_req_arbiter: expected issues are queued at stimulus time and
// compared against every llc_valid/llc_ready handshake.
module tb_llc_req_arbiter;
  import llc_req_arbiter_pkg::*;

  localparam int unsigned Depth    = 4;
  localparam int unsigned MaxBurst = 3;
  localparam int unsigned Timeout  = 64;
  localparam int unsigned CntW     = $clog2(Depth) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 l1_valid = 1'b0, l1_ready;
  logic [CMDSIZE-1:0]   l1_cmd = '0;
  logic [ADDR_BITS-1:0] l1_addr = '0;
  logic                 snp_valid = 1'b0, snp_ready;
  logic [CMDSIZE-1:0]   snp_cmd = '0;
  logic [ADDR_BITS-1:0] snp_addr = '0;
  logic                 llc_valid, llc_ready = 1'b0, llc_done = 1'b0;
  logic [CMDSIZE-1:0]   llc_cmd;
  logic [ADDR_BITS-1:0] llc_addr;
  logic                 busy, illegal_cmd, timeout;
  logic [CntW-1:0]      l1_fifo_count;
`ifdef LLC_ARB_STATS_EN
  logic [31:0]          snp_grants, l1_grants, timeouts;
`endif

  always #5 clk = ~clk;

  llc_req_arbiter #(
    .L1_FIFO_DEPTH   (Depth),
    .MAX_SNOOP_BURST (MaxBurst),
    .DONE_TIMEOUT    (Timeout)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .l1_valid      (l1_valid),
    .l1_ready      (l1_ready),
    .l1_cmd        (l1_cmd),
    .l1_addr       (l1_addr),
    .snp_valid     (snp_valid),
    .snp_ready     (snp_ready),
    .snp_cmd       (snp_cmd),
    .snp_addr      (snp_addr),
    .llc_valid     (llc_valid),
    .llc_ready     (llc_ready),
    .llc_cmd       (llc_cmd),
    .llc_addr      (llc_addr),
    .llc_done      (llc_done),
    .busy          (busy),
    .illegal_cmd   (illegal_cmd),
    .timeout       (timeout),
`ifdef LLC_ARB_STATS_EN
    .snp_grants    (snp_grants),
    .l1_grants     (l1_grants),
    .timeouts      (timeouts),
`endif
    .l1_fifo_count (l1_fifo_count)
  );

  typedef struct packed {
    logic [CMDSIZE-1:0]   cmd;
    logic [ADDR_BITS-1:0] addr;
  } txn_t;

  txn_t exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every LLC handshake must match the next expected transaction.
  always @(negedge clk) begin
    if (rst_n && llc_valid && llc_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("issue_unexpected", 64'(exp_q.size()), 64'd1);
      end else begin
        txn_t t;
        t = exp_q.pop_front();
        check_eq("issue_cmd", 64'(llc_cmd), 64'(t.cmd));
        check_eq("issue_addr", 64'(llc_addr), 64'(t.addr));
      end
    end
  end

  task automatic send_l1(input logic [CMDSIZE-1:0] cmd, input logic [ADDR_BITS-1:0] addr);
    int n = 0;
    l1_valid = 1'b1;
    l1_cmd   = cmd;
    l1_addr  = addr;
    while (!l1_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("l1_accept", 64'(l1_ready), 64'd1);
    tick();
    l1_valid = 1'b0;
  endtask

  task automatic send_snp(input logic [CMDSIZE-1:0] cmd, input logic [ADDR_BITS-1:0] addr);
    int n = 0;
    snp_valid = 1'b1;
    snp_cmd   = cmd;
    snp_addr  = addr;
    while (!snp_ready && n < 100) begin
      tick();
      n++;
    end
    check_eq("snp_accept", 64'(snp_ready), 64'd1);
    tick();
    snp_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check_eq("idle_wait", 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;

    // Reset values
    tick();
    check_eq("rst_llc_valid", 64'(llc_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_l1_ready", 64'(l1_ready), 64'd0);
    check_eq("rst_snp_ready", 64'(snp_ready), 64'd0);
    check_eq("rst_count", 64'(l1_fifo_count), 64'd0);
    check_eq("rst_illegal", 64'(illegal_cmd), 64'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_l1_ready", 64'(l1_ready), 64'd1);
    check_eq("post_rst_snp_ready", 64'(snp_ready), 64'd1);

    // Latency: accepted in cycle 0, llc_valid in cycle 2, done in cycle 5, idle in 6
    llc_ready = 1'b1;
    exp_q.push_back('{cmd: RD_L1D, addr: 32'h0000_1040});
    l1_valid = 1'b1; l1_cmd = RD_L1D; l1_addr = 32'h0000_1040;
    tick();
    l1_valid = 1'b0;
    check_eq("lat_c1_valid", 64'(llc_valid), 64'd0);
    check_eq("lat_c1_count", 64'(l1_fifo_count), 64'd1);
    tick();
    check_eq("lat_c2_valid", 64'(llc_valid), 64'd1);
    check_eq("lat_c2_addr", 64'(llc_addr), 64'h1040);
    tick();
    check_eq("lat_c3_valid", 64'(llc_valid), 64'd0);
    check_eq("lat_c3_busy", 64'(busy), 64'd1);
    tick();
    tick();
    llc_done = 1'b1;
    check_eq("lat_c5_busy", 64'(busy), 64'd1);
    tick();
    llc_done = 1'b0;
    check_eq("lat_c6_busy", 64'(busy), 64'd0);

    // Fill the FIFO behind a stalled snoop; order must be preserved
    llc_ready = 1'b0;
    exp_q.push_back('{cmd: SNP_WR, addr: 32'h0000_9000});
    send_snp(SNP_WR, 32'h0000_9000);
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back('{cmd: RD_L1D, addr: 32'(i * 32'h100)});
      send_l1(RD_L1D, 32'(i * 32'h100));
    end
    check_eq("full_l1_ready", 64'(l1_ready), 64'd0);
    check_eq("full_count", 64'(l1_fifo_count), 64'd4);
    llc_ready = 1'b1;
    llc_done  = 1'b1;
    tick();
    check_eq("full_pop_cycle_ready", 64'(l1_ready), 64'd0);
    tick();
    check_eq("after_pop_ready", 64'(l1_ready), 64'd1);
    check_eq("after_pop_count", 64'(l1_fifo_count), 64'd3);
    wait_drain("fill_drain");
    llc_ready = 1'b0;
    llc_done  = 1'b0;
    wait_idle();

    // Snoop burst limit: S,S,S,L1,S,S,S,L1 after the stalled first L1
    llc_done = 1'b1;
    exp_q.push_back('{cmd: RD_L1D, addr: 32'h0000_00A0});
    for (int i = 0; i < 3; i++) exp_q.push_back('{cmd: SNP_RD, addr: 32'(32'h5000 + i)});
    exp_q.push_back('{cmd: WR_L1D, addr: 32'h0000_00B0});
    for (int i = 3; i < 6; i++) exp_q.push_back('{cmd: SNP_RD, addr: 32'(32'h5000 + i)});
    exp_q.push_back('{cmd: CLR, addr: 32'h0000_00C0});
    send_l1(RD_L1D, 32'h0000_00A0);
    n = 0;
    while (!busy && n < 20) begin tick(); n++; end
    send_l1(WR_L1D, 32'h0000_00B0);
    send_l1(CLR, 32'h0000_00C0);
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int m = 0;
          snp_valid = 1'b1;
          snp_cmd   = SNP_RD;
          snp_addr  = 32'(32'h5000 + i);
          while (!snp_ready && m < 100) begin tick(); m++; end
          check_eq("burst_snp_accept", 64'(snp_ready), 64'd1);
          tick();
        end
        snp_valid = 1'b0;
      end
      begin
        tick(); tick(); tick();
        llc_ready = 1'b1;
      end
    join
    wait_drain("burst_drain");
    llc_ready = 1'b0;
    llc_done  = 1'b0;
    wait_idle();

    // Both ports illegal in one cycle: a single pulse, nothing stored or issued
    l1_valid = 1'b1;  l1_cmd  = 4'd7; l1_addr  = 32'hDEAD;
    snp_valid = 1'b1; snp_cmd = 4'd1; snp_addr = 32'hBEEF;
    tick();
    l1_valid = 1'b0;
    snp_valid = 1'b0;
    check_eq("illegal_pulse", 64'(illegal_cmd), 64'd1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (illegal_cmd) pulses++;
    end
    check_eq("illegal_single", 64'(pulses), 64'd0);
    check_eq("illegal_count", 64'(l1_fifo_count), 64'd0);
    check_eq("illegal_busy", 64'(busy), 64'd0);

    // Timeout: LLC accepts but never completes
    llc_ready = 1'b1;
    exp_q.push_back('{cmd: SNP_INV, addr: 32'h0000_7000});
    send_snp(SNP_INV, 32'h0000_7000);
    n = 0;
    while (!llc_valid && n < 20) begin tick(); n++; end
    check_eq("to_issue_seen", 64'(llc_valid), 64'd1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!timeout && n < 200);
    check_eq("to_latency", 64'(n), 64'(Timeout + 1));
    check_eq("to_idle", 64'(busy), 64'd0);
    tick();
    check_eq("to_one_cycle", 64'(timeout), 64'd0);
    llc_done = 1'b1;
    tick();
    llc_done = 1'b0;
    tick();
    check_eq("late_done_busy", 64'(busy), 64'd0);
    check_eq("late_done_valid", 64'(llc_valid), 64'd0);

    // Reset during WAIT_DONE with three queued requests
    exp_q.push_back('{cmd: PRT, addr: 32'h0000_8000});
    send_l1(PRT, 32'h0000_8000);
    n = 0;
    while (!llc_valid && n < 20) begin tick(); n++; end
    tick();
    for (int i = 0; i < 3; i++) send_l1(RD_L1I, 32'(32'h8100 + i * 32'h10));
    check_eq("pre_rst_count", 64'(l1_fifo_count), 64'd3);
    check_eq("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(llc_valid), 64'd0);
    check_eq("mid_rst_count", 64'(l1_fifo_count), 64'd0);
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_eq("post_rst2_busy", 64'(busy), 64'd0);
    check_eq("post_rst2_count", 64'(l1_fifo_count), 64'd0);
    check_eq("post_rst2_l1_ready", 64'(l1_ready), 64'd1);
    check_eq("final_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
